// File: rtl/amp_ctrl_seq.sv
// amp_ctrl_seq: MA12070 power-up, register-table configuration and mute sequencer.
// All outputs registered; table entries are written through a req/ack byte-write master.
module amp_ctrl_seq #(
  parameter int PWRUP_CYC  = 27000,
  parameter int UNMUTE_CYC = 2700,
  parameter int NUM_WRITES = 4,
  parameter int RETRIES    = 3,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       ena,
  input  logic       i2s_locked,
  input  logic       mute_req,
  output logic [3:0] tbl_idx,
  input  logic [7:0] tbl_reg,
  input  logic [7:0] tbl_val,
  output logic       m_req,
  output logic [7:0] m_reg,
  output logic [7:0] m_data,
  input  logic       m_ack,
  input  logic       m_nack,
  output logic       amp_nenable,
  output logic       amp_nmute,
  output logic       err,
  output logic [2:0] state_mon
);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    PWRUP     = 3'd1,
    CFG       = 3'd2,
    WAIT_LOCK = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam int               RTY_W     = $clog2(RETRIES + 2);
  localparam logic [CNT_W-1:0] PWRUP_LD  = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] UNMUTE_LD = CNT_W'(UNMUTE_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(RETRIES);
  localparam logic [3:0]       IDX_LAST  = 4'(NUM_WRITES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [3:0]       idx_q, idx_d;
  logic             req_q, req_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       data_q, data_d;
  logic             nen_q, nen_d;
  logic             nmute_q, nmute_d;
  logic             err_q, err_d;
  logic             clean;

  assign clean = i2s_locked && !mute_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    req_d   = req_q;
    reg_d   = reg_q;
    data_d  = data_q;
    err_d   = err_q;

    if (!ena) begin
      state_d = OFF;
      req_d   = 1'b0;
      idx_d   = 4'd0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d = PWRUP;
          cnt_d   = PWRUP_LD;
          err_d   = 1'b0;
        end
        PWRUP: begin
          if (cnt_q == '0) begin
            retry_d = '0;
            idx_d   = 4'd0;
            req_d   = 1'b0;
            if (NUM_WRITES == 0) begin
              state_d = WAIT_LOCK;
              cnt_d   = UNMUTE_LD;
            end else begin
              state_d = CFG;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        CFG: begin
          // Idle cycle latches the table lookup; responses only count while a request is up.
          if (!req_q) begin
            reg_d  = tbl_reg;
            data_d = tbl_val;
            req_d  = 1'b1;
          end else if (m_nack) begin
            req_d = 1'b0;
            if (retry_q == RTY_LAST) begin
              state_d = FAULT;
              err_d   = 1'b1;
            end else begin
              retry_d = retry_q + RTY_W'(1);
            end
          end else if (m_ack) begin
            req_d   = 1'b0;
            retry_d = '0;
            idx_d   = idx_q + 4'd1;
            if (idx_q == IDX_LAST) begin
              state_d = WAIT_LOCK;
              cnt_d   = UNMUTE_LD;
            end
          end
        end
        WAIT_LOCK: begin
          if (!clean) begin
            cnt_d = UNMUTE_LD;
          end else if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          if (!clean) begin
            state_d = WAIT_LOCK;
            cnt_d   = UNMUTE_LD;
          end
        end
        FAULT: begin
          err_d = 1'b1;
          req_d = 1'b0;
        end
        default: begin
          state_d = OFF;
          req_d   = 1'b0;
        end
      endcase
    end

    // Pin levels follow the state being entered so they change with state_mon.
    nen_d   = !(state_d == PWRUP || state_d == CFG || state_d == WAIT_LOCK || state_d == RUN);
    nmute_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= OFF;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= 4'd0;
      req_q   <= 1'b0;
      reg_q   <= 8'd0;
      data_q  <= 8'd0;
      nen_q   <= 1'b1;
      nmute_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      nen_q   <= nen_d;
      nmute_q <= nmute_d;
      err_q   <= err_d;
    end
  end

  assign tbl_idx     = idx_q;
  assign m_req       = req_q;
  assign m_reg       = reg_q;
  assign m_data      = data_q;
  assign amp_nenable = nen_q;
  assign amp_nmute   = nmute_q;
  assign err         = err_q;
  assign state_mon   = state_q;

endmodule

// File: tb/tb_amp_ctrl_seq.sv
// Bench for amp_ctrl_seq: randomized table/ack/nack/lock stimulus against a request-level model.
module tb_amp_ctrl_seq;
  localparam int P  = 20;
  localparam int U  = 12;
  localparam int NW = 4;
  localparam int R  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetb, ena, lock, mute_req, m_ack, m_nack;
  logic [3:0] tbl_idx;
  logic [7:0] tbl_reg, tbl_val, m_reg, m_data;
  logic       m_req, amp_nenable, amp_nmute, err;
  logic [2:0] state_mon;

  logic       ena0, m_ack0, m_nack0;
  logic [3:0] tbl_idx0;
  logic [7:0] tbl_reg0, tbl_val0, m_reg0, m_data0;
  logic       m_req0, amp_nenable0, amp_nmute0, err0;
  logic [2:0] state_mon0;
  logic       saw_req0 = 1'b0;

  logic [7:0] tbl_r [16];
  logic [7:0] tbl_v [16];
  int plan0 [NW];
  int plan  [NW];
  int issues[NW];
  int fix_dly;
  int n_vec = 0;
  int n_err = 0;

  assign tbl_reg  = tbl_r[tbl_idx];
  assign tbl_val  = tbl_v[tbl_idx];
  assign tbl_reg0 = tbl_r[tbl_idx0];
  assign tbl_val0 = tbl_v[tbl_idx0];

  amp_ctrl_seq #(.PWRUP_CYC(P), .UNMUTE_CYC(U), .NUM_WRITES(NW), .RETRIES(R), .CNT_W(16)) dut (
    .clk(clk), .resetb(resetb), .ena(ena), .i2s_locked(lock), .mute_req(mute_req),
    .tbl_idx(tbl_idx), .tbl_reg(tbl_reg), .tbl_val(tbl_val),
    .m_req(m_req), .m_reg(m_reg), .m_data(m_data), .m_ack(m_ack), .m_nack(m_nack),
    .amp_nenable(amp_nenable), .amp_nmute(amp_nmute), .err(err), .state_mon(state_mon)
  );

  amp_ctrl_seq #(.PWRUP_CYC(P), .UNMUTE_CYC(U), .NUM_WRITES(0), .RETRIES(R), .CNT_W(16)) dut0 (
    .clk(clk), .resetb(resetb), .ena(ena0), .i2s_locked(lock), .mute_req(mute_req),
    .tbl_idx(tbl_idx0), .tbl_reg(tbl_reg0), .tbl_val(tbl_val0),
    .m_req(m_req0), .m_reg(m_reg0), .m_data(m_data0), .m_ack(m_ack0), .m_nack(m_nack0),
    .amp_nenable(amp_nenable0), .amp_nmute(amp_nmute0), .err(err0), .state_mon(state_mon0)
  );

  always @(posedge clk) if (m_req0 === 1'b1) saw_req0 <= 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic run_cfg(output bit faulted);
    int idx, consec, dly;
    bit do_nack;
    faulted = 0;
    idx     = 0;
    consec  = 0;
    while (idx < NW) begin
      issues[idx]++;
      chk("cfg_state", state_mon, 2);
      chk("m_req_up", m_req, 1);
      chk("m_reg", m_reg, tbl_r[idx]);
      chk("m_data", m_data, tbl_v[idx]);
      chk("tbl_idx", tbl_idx, idx);
      dly = (fix_dly >= 0) ? fix_dly : $urandom_range(0, 5);
      repeat (dly) begin
        step();
        chk("req_hold", {m_req, m_reg, m_data}, {1'b1, tbl_r[idx], tbl_v[idx]});
      end
      do_nack = (plan[idx] > 0);
      if (do_nack) begin
        plan[idx]--;
        consec++;
        m_nack = 1'b1;
        m_ack  = 1'($urandom_range(0, 1));
      end else begin
        m_ack = 1'b1;
      end
      step();
      m_ack  = 1'b0;
      m_nack = 1'b0;
      chk("req_drop", m_req, 0);
      if (do_nack && consec == R + 1) begin
        chk("fault_state", state_mon, 5);
        chk("fault_err", err, 1);
        chk("fault_nen", amp_nenable, 1);
        chk("fault_nmute", amp_nmute, 0);
        faulted = 1;
        return;
      end
      if (!do_nack) begin
        idx++;
        consec = 0;
      end
      if (idx == NW) begin
        chk("cfg_done_state", state_mon, 3);
        return;
      end
      // A response while no request is up must not advance anything.
      if ($urandom_range(0, 2) == 0) begin
        m_ack  = 1'($urandom_range(0, 1));
        m_nack = ~m_ack;
      end
      step();
      m_ack  = 1'b0;
      m_nack = 1'b0;
    end
  endtask

  task automatic power_up(output bit faulted);
    int c;
    lock     = 1'b1;
    mute_req = 1'b0;
    ena      = 1'b1;
    step();
    chk("nen_fall", amp_nenable, 0);
    chk("pwrup_state", state_mon, 1);
    chk("err_clear", err, 0);
    c = 0;
    while (m_req !== 1'b1 && c < P + 10) begin
      step();
      c++;
    end
    chk("first_req_lat", c, P + 1);
    faulted = 0;
    if (m_req !== 1'b1) begin
      faulted = 1;
      return;
    end
    run_cfg(faulted);
    if (!faulted) begin
      c = 0;
      while (amp_nmute !== 1'b1 && c < U + 10) begin
        chk("muted_wait", amp_nmute, 0);
        step();
        c++;
      end
      chk("unmute_lat", c, U);
      chk("run_state", state_mon, 4);
    end
  endtask

  task automatic set_dirty(input bit use_mute);
    if (use_mute) mute_req = 1'b1;
    else          lock     = 1'b0;
  endtask

  task automatic lock_loss(input bit use_mute, input int glitch_at);
    int c;
    set_dirty(use_mute);
    step();
    lock     = 1'b1;
    mute_req = 1'b0;
    chk("loss_mute", amp_nmute, 0);
    chk("loss_state", state_mon, 3);
    if (glitch_at > 0) begin
      repeat (glitch_at) step();
      chk("mid_count_mute", amp_nmute, 0);
      set_dirty(~use_mute);
      step();
      lock     = 1'b1;
      mute_req = 1'b0;
    end
    c = 0;
    while (amp_nmute !== 1'b1 && c < U + 10) begin
      step();
      c++;
    end
    chk("reunmute_lat", c, U);
  endtask

  initial begin
    bit faulted;
    bit exp_fault;
    int exp_iss, c;

    resetb = 1'b0; ena = 1'b0; ena0 = 1'b0; lock = 1'b1; mute_req = 1'b0;
    m_ack = 1'b0; m_nack = 1'b0; m_ack0 = 1'b0; m_nack0 = 1'b0; fix_dly = -1;
    for (int i = 0; i < 16; i++) begin
      tbl_r[i] = 8'($urandom);
      tbl_v[i] = 8'($urandom);
    end
    repeat (3) step();
    chk("rst_nen", amp_nenable, 1);
    chk("rst_nmute", amp_nmute, 0);
    chk("rst_req", m_req, 0);
    chk("rst_regdata", {m_reg, m_data}, 0);
    chk("rst_idx", tbl_idx, 0);
    chk("rst_err", err, 0);
    chk("rst_state", state_mon, 0);
    resetb = 1'b1;
    step();
    chk("off_hold", state_mon, 0);

    // Zero-entry build goes straight from power-up to waiting for lock.
    ena0 = 1'b1;
    step();
    chk("nw0_nen", amp_nenable0, 0);
    c = 0;
    while (state_mon0 !== 3'd3 && c < P + 10) begin
      step();
      c++;
    end
    chk("nw0_wait_lat", c, P);
    c = 0;
    while (amp_nmute0 !== 1'b1 && c < U + 10) begin
      step();
      c++;
    end
    chk("nw0_unmute_lat", c, U);
    chk("nw0_no_req", saw_req0, 0);
    ena0 = 1'b0;
    step();
    chk("nw0_off", state_mon0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NW; i++) begin
        tbl_r[i]  = 8'($urandom);
        tbl_v[i]  = 8'($urandom);
        plan0[i]  = (r < 3) ? 0 : $urandom_range(0, 2);
        issues[i] = 0;
      end
      if (r == 1) plan0[2] = 2;
      if (r == 2) plan0[1] = 4;
      if (r >= 3 && $urandom_range(0, 3) == 0) plan0[$urandom_range(0, NW - 1)] = 4;
      for (int i = 0; i < NW; i++) plan[i] = plan0[i];
      fix_dly = (r == 0) ? 5 : -1;

      power_up(faulted);

      exp_fault = 0;
      for (int i = 0; i < NW; i++) begin
        if (exp_fault)           exp_iss = 0;
        else if (plan0[i] > R) begin
          exp_iss   = R + 1;
          exp_fault = 1;
        end else                 exp_iss = plan0[i] + 1;
        chk("issue_count", issues[i], exp_iss);
      end
      chk("err_model", err, exp_fault);

      if (exp_fault) begin
        repeat (3) step();
        chk("fault_stays", state_mon, 5);
        chk("fault_req", m_req, 0);
      end else begin
        lock_loss(1'($urandom_range(0, 1)), (r % 2 == 1) ? $urandom_range(1, U - 2) : 0);
      end

      ena = 1'b0;
      step();
      chk("off_state", state_mon, 0);
      chk("off_nen", amp_nenable, 1);
      chk("off_nmute", amp_nmute, 0);
      chk("off_req", m_req, 0);
      chk("off_idx", tbl_idx, 0);
      chk("off_err_sticky", err, exp_fault);
      step();
    end

    // Abort an outstanding transfer, then deliver a stale ack.
    for (int i = 0; i < NW; i++) begin
      plan0[i] = 0;
      plan[i]  = 0;
      issues[i] = 0;
    end
    ena = 1'b1;
    step();
    c = 0;
    while (m_req !== 1'b1 && c < P + 10) begin
      step();
      c++;
    end
    chk("abort_req_lat", c, P + 1);
    repeat ($urandom_range(0, 3)) step();
    chk("abort_req_up", m_req, 1);
    ena = 1'b0;
    step();
    chk("abort_req", m_req, 0);
    chk("abort_nen", amp_nenable, 1);
    chk("abort_state", state_mon, 0);
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    chk("late_ack_state", state_mon, 0);
    chk("late_ack_idx", tbl_idx, 0);
    chk("late_ack_req", m_req, 0);

    // Full restart, then asynchronous reset while running.
    fix_dly = -1;
    power_up(faulted);
    chk("restart_ok", state_mon, 4);
    #2 resetb = 1'b0;
    #1;
    chk("arst_nen", amp_nenable, 1);
    chk("arst_nmute", amp_nmute, 0);
    chk("arst_req", m_req, 0);
    chk("arst_regdata", {m_reg, m_data}, 0);
    chk("arst_idx", tbl_idx, 0);
    chk("arst_state", state_mon, 0);
    ena = 1'b0;
    step();
    resetb = 1'b1;
    step();
    chk("post_arst_state", state_mon, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
